// File: rtl/gray_seq_pkg.sv
// Shared definitions for the Gray-sequence decoder: code constants, FSM encoding
// and the Gray-code-to-index mapping.
package gray_seq_pkg;

    localparam logic [2:0] S0 = 3'b000;
    localparam logic [2:0] S1 = 3'b100;
    localparam logic [2:0] S2 = 3'b110;
    localparam logic [2:0] S3 = 3'b111;
    localparam logic [2:0] S4 = 3'b101;
    localparam logic [2:0] S5 = 3'b001;
    localparam logic [2:0] S6 = 3'b011;
    localparam logic [2:0] S7 = 3'b010;

    typedef enum logic {
        SYNC  = 1'b0,
        TRACK = 1'b1
    } state_t;

    function automatic logic [2:0] code_to_idx(input logic [2:0] code);
        logic [2:0] idx;
        idx = '0;
        case (code)
            S0: idx = 3'd0;
            S1: idx = 3'd1;
            S2: idx = 3'd2;
            S3: idx = 3'd3;
            S4: idx = 3'd4;
            S5: idx = 3'd5;
            S6: idx = 3'd6;
            S7: idx = 3'd7;
            default: idx = '0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/gray_seq_decoder_if.sv
// Bundles the Gray-code input, clear and all decoder outputs; the decoder is the slave.
interface gray_seq_decoder_if #(
    parameter int POS_W  = 16,
    parameter int ERRC_W = 8
);
    logic [2:0]              code;
    logic                    clr;
    logic signed [POS_W-1:0] pos;
    logic [2:0]              idx;
    logic                    dir;
    logic                    step_valid;
    logic                    err;
    logic [ERRC_W-1:0]       err_cnt;
    logic                    locked;

    modport master (
        output code, clr,
        input  pos, idx, dir, step_valid, err, err_cnt, locked
    );

    modport slave (
        input  code, clr,
        output pos, idx, dir, step_valid, err, err_cnt, locked
    );
endinterface

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for an asynchronous bus, with a fill flag that marks when
// the last stage holds a value actually sampled since reset.
module bit_sync #(
    parameter int WIDTH  = 3,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid
);

    logic [WIDTH-1:0]  stage [STAGES];
    logic [STAGES-1:0] fill;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
            fill <= '0;
        end else begin
            stage[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
            fill <= {fill[STAGES-2:0], 1'b1};
        end
    end

    assign q     = stage[STAGES-1];
    assign valid = fill[STAGES-1];

endmodule

// File: rtl/gray_seq_decoder.sv
// Decodes a synchronized 3-bit Gray step sequence into a signed position, direction,
// step pulses and an error count for illegal jumps.
module gray_seq_decoder
    import gray_seq_pkg::*;
#(
    parameter int POS_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int ERRC_W      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    gray_seq_decoder_if.slave  bus
);

    localparam logic signed [POS_W-1:0] POS_ONE  = 1;
    localparam logic [ERRC_W-1:0]       ERRC_ONE = 1;

    logic [2:0]              code_s;
    logic                    code_v;
    logic [2:0]              new_idx;
    logic [2:0]              delta;

    state_t                  state;
    logic signed [POS_W-1:0] pos_q;
    logic [2:0]              idx_q;
    logic                    dir_q;
    logic                    step_q;
    logic                    err_q;
    logic [ERRC_W-1:0]       errc_q;
    logic                    locked_q;

    bit_sync #(
        .WIDTH  (3),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.code),
        .q     (code_s),
        .valid (code_v)
    );

    // 3-bit subtraction wraps naturally, so 7->0 gives 1 and 0->7 gives 7.
    always_comb begin
        new_idx = code_to_idx(code_s);
        delta   = new_idx - idx_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= SYNC;
            pos_q    <= '0;
            idx_q    <= '0;
            dir_q    <= 1'b0;
            step_q   <= 1'b0;
            err_q    <= 1'b0;
            errc_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            step_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                SYNC: begin
                    if (code_v) begin
                        idx_q    <= new_idx;
                        locked_q <= 1'b1;
                        state    <= TRACK;
                    end
                end
                TRACK: begin
                    case (delta)
                        3'd0: ;
                        3'd1: begin
                            pos_q  <= pos_q + POS_ONE;
                            dir_q  <= 1'b0;
                            idx_q  <= new_idx;
                            step_q <= 1'b1;
                        end
                        3'd7: begin
                            pos_q  <= pos_q - POS_ONE;
                            dir_q  <= 1'b1;
                            idx_q  <= new_idx;
                            step_q <= 1'b1;
                        end
                        default: begin
                            err_q <= 1'b1;
                            idx_q <= new_idx;
                            if (errc_q != '1) begin
                                errc_q <= errc_q + ERRC_ONE;
                            end
                        end
                    endcase
                end
                default: state <= SYNC;
            endcase
            // Clear wins over any same-cycle step or error on the counters only.
            if (bus.clr) begin
                pos_q  <= '0;
                errc_q <= '0;
            end
        end
    end

    assign bus.pos        = pos_q;
    assign bus.idx        = idx_q;
    assign bus.dir        = dir_q;
    assign bus.step_valid = step_q;
    assign bus.err        = err_q;
    assign bus.err_cnt    = errc_q;
    assign bus.locked     = locked_q;

endmodule

// File: tb/tb_gray_seq_decoder.sv
// Self-checking bench for gray_seq_decoder: per-cycle scoreboard against a behavioural
// model, a table of settled-state expectations, and hand-written corner sequences.
module tb_gray_seq_decoder;

    localparam int POS_W       = 16;
    localparam int SYNC_STAGES = 2;
    localparam int ERRC_W      = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gray_seq_decoder_if #(.POS_W(POS_W), .ERRC_W(ERRC_W)) bus ();

    gray_seq_decoder #(
        .POS_W       (POS_W),
        .SYNC_STAGES (SYNC_STAGES),
        .ERRC_W      (ERRC_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [POS_W-1:0]  pos;
        logic [2:0]        idx;
        logic              dir;
        logic              sv;
        logic              err;
        logic [ERRC_W-1:0] errc;
        logic              locked;
    } obs_t;

    typedef struct {
        logic [2:0]        code;
        int                hold;
        logic              clr;
        logic              rn;
        logic [POS_W-1:0]  e_pos;
        int                e_idx;
        int                e_dir;
        int                e_errc;
        int                e_locked;
        int                e_steps;
        int                e_errs;
    } row_t;

    obs_t exp_q[$];
    row_t rows[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   steps_seen = 0;
    int   errs_seen = 0;

    logic [2:0] gray_of [8] = '{3'b000, 3'b100, 3'b110, 3'b111, 3'b101, 3'b001, 3'b011, 3'b010};
    int         idx_of  [8] = '{0, 5, 7, 6, 1, 4, 2, 3};

    // Behavioural model state
    logic [2:0]        m_pipe [SYNC_STAGES];
    logic              m_pv   [SYNC_STAGES];
    logic              m_locked;
    int                m_idx;
    logic [POS_W-1:0]  m_pos;
    logic              m_dir, m_sv, m_err;
    logic [ERRC_W-1:0] m_errc;

    task automatic model_edge(input logic [2:0] c, input logic cl, input logic rn);
        int d;
        logic [2:0] cs;
        logic cv;
        if (!rn) begin
            m_locked = 1'b0; m_idx = 0; m_pos = '0; m_dir = 1'b0;
            m_sv = 1'b0; m_err = 1'b0; m_errc = '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                m_pipe[i] = 3'b000;
                m_pv[i]   = 1'b0;
            end
        end else begin
            cs = m_pipe[SYNC_STAGES-1];
            cv = m_pv[SYNC_STAGES-1];
            m_sv = 1'b0;
            m_err = 1'b0;
            if (!m_locked) begin
                if (cv) begin
                    m_idx = idx_of[cs];
                    m_locked = 1'b1;
                end
            end else begin
                d = (idx_of[cs] - m_idx + 8) % 8;
                if (d == 1) begin
                    m_pos = m_pos + 1'b1; m_dir = 1'b0; m_idx = idx_of[cs]; m_sv = 1'b1;
                end else if (d == 7) begin
                    m_pos = m_pos - 1'b1; m_dir = 1'b1; m_idx = idx_of[cs]; m_sv = 1'b1;
                end else if (d != 0) begin
                    m_err = 1'b1; m_idx = idx_of[cs];
                    if (m_errc != {ERRC_W{1'b1}}) m_errc = m_errc + 1'b1;
                end
            end
            if (cl) begin
                m_pos = '0;
                m_errc = '0;
            end
            for (int i = SYNC_STAGES - 1; i > 0; i--) begin
                m_pipe[i] = m_pipe[i-1];
                m_pv[i]   = m_pv[i-1];
            end
            m_pipe[0] = c;
            m_pv[0]   = 1'b1;
        end
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick(input logic [2:0] c, input logic cl, input logic rn);
        obs_t e, got;
        bus.code = c;
        bus.clr  = cl;
        rst_n    = rn;
        model_edge(c, cl, rn);
        e.pos = m_pos; e.idx = 3'(m_idx); e.dir = m_dir; e.sv = m_sv;
        e.err = m_err; e.errc = m_errc; e.locked = m_locked;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got.pos = bus.pos; got.idx = bus.idx; got.dir = bus.dir; got.sv = bus.step_valid;
        got.err = bus.err; got.errc = bus.err_cnt; got.locked = bus.locked;
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL cycle %0d: got pos=%h idx=%0d dir=%b sv=%b err=%b errc=%0d lock=%b, expected pos=%h idx=%0d dir=%b sv=%b err=%b errc=%0d lock=%b",
                     cyc, got.pos, got.idx, got.dir, got.sv, got.err, got.errc, got.locked,
                     e.pos, e.idx, e.dir, e.sv, e.err, e.errc, e.locked);
        end
        if (bus.step_valid === 1'b1) steps_seen++;
        if (bus.err === 1'b1) errs_seen++;
        cyc++;
    endtask

    task automatic add(input logic [2:0] c, input int h, input logic cl, input logic rn,
                       input logic [POS_W-1:0] p, input int i, input int d, input int ec,
                       input int lk, input int st, input int er);
        row_t r;
        r.code = c; r.hold = h; r.clr = cl; r.rn = rn; r.e_pos = p; r.e_idx = i;
        r.e_dir = d; r.e_errc = ec; r.e_locked = lk; r.e_steps = st; r.e_errs = er;
        rows.push_back(r);
    endtask

    int cur;
    logic [2:0] nc;

    initial begin
        bus.code = 3'b000;
        bus.clr  = 1'b0;

        //   code    hold clr rn  pos       idx dir errc lock steps errs
        add(3'b000, 3, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0);
        add(3'b000, 5, 0, 1, 16'h0000, 0, 0, 0, 1, 0, 0);
        add(3'b100, 4, 0, 1, 16'h0001, 1, 0, 0, 1, 1, 0);
        add(3'b110, 4, 0, 1, 16'h0002, 2, 0, 0, 1, 1, 0);
        add(3'b111, 4, 0, 1, 16'h0003, 3, 0, 0, 1, 1, 0);
        add(3'b101, 4, 0, 1, 16'h0004, 4, 0, 0, 1, 1, 0);
        add(3'b001, 4, 0, 1, 16'h0005, 5, 0, 0, 1, 1, 0);
        add(3'b011, 4, 0, 1, 16'h0006, 6, 0, 0, 1, 1, 0);
        add(3'b010, 4, 0, 1, 16'h0007, 7, 0, 0, 1, 1, 0);
        add(3'b000, 4, 0, 1, 16'h0008, 0, 0, 0, 1, 1, 0);
        add(3'b000, 4, 1, 1, 16'h0000, 0, 0, 0, 1, 0, 0);
        add(3'b010, 4, 0, 1, 16'hFFFF, 7, 1, 0, 1, 1, 0);
        add(3'b011, 4, 0, 1, 16'hFFFE, 6, 1, 0, 1, 1, 0);
        add(3'b010, 4, 0, 1, 16'hFFFF, 7, 0, 0, 1, 1, 0);
        add(3'b000, 4, 0, 1, 16'h0000, 0, 0, 0, 1, 1, 0);
        add(3'b111, 4, 0, 1, 16'h0000, 3, 0, 1, 1, 0, 1);
        add(3'b101, 4, 0, 1, 16'h0001, 4, 0, 1, 1, 1, 0);
        add(3'b101, 4, 1, 1, 16'h0000, 4, 0, 0, 1, 0, 0);

        foreach (rows[k]) begin
            steps_seen = 0;
            errs_seen  = 0;
            for (int n = 0; n < rows[k].hold; n++) tick(rows[k].code, rows[k].clr, rows[k].rn);
            check($sformatf("row%0d pos", k),    {bus.pos},        {rows[k].e_pos});
            check($sformatf("row%0d idx", k),    {bus.idx},        rows[k].e_idx);
            check($sformatf("row%0d dir", k),    {bus.dir},        rows[k].e_dir);
            check($sformatf("row%0d errc", k),   {bus.err_cnt},    rows[k].e_errc);
            check($sformatf("row%0d locked", k), {bus.locked},     rows[k].e_locked);
            check($sformatf("row%0d steps", k),  steps_seen,       rows[k].e_steps);
            check($sformatf("row%0d errs", k),   errs_seen,        rows[k].e_errs);
        end

        // Fast forward to the positive limit, one step per cycle.
        cur = 4;
        for (int n = 0; n < 32767; n++) begin
            cur = (cur + 1) % 8;
            tick(gray_of[cur], 1'b0, 1'b1);
        end
        for (int n = 0; n < 3; n++) tick(gray_of[cur], 1'b0, 1'b1);
        check("pos at max", {bus.pos}, 16'h7FFF);

        cur = (cur + 1) % 8;
        for (int n = 0; n < 3; n++) tick(gray_of[cur], 1'b0, 1'b1);
        check("wrap fwd pos", {bus.pos}, 16'h8000);
        cur = (cur + 7) % 8;
        for (int n = 0; n < 3; n++) tick(gray_of[cur], 1'b0, 1'b1);
        check("wrap back pos", {bus.pos}, 16'h7FFF);
        check("wrap back dir", {bus.dir}, 1);
        cur = (cur + 1) % 8;
        for (int n = 0; n < 3; n++) tick(gray_of[cur], 1'b0, 1'b1);
        check("wrap fwd2 pos", {bus.pos}, 16'h8000);

        // Clear lands on the same edge as a step.
        cur = (cur + 1) % 8;
        tick(gray_of[cur], 1'b0, 1'b1);
        for (int n = 0; n < SYNC_STAGES - 1; n++) tick(gray_of[cur], 1'b0, 1'b1);
        tick(gray_of[cur], 1'b1, 1'b1);
        check("clr+step sv", {bus.step_valid}, 1);
        check("clr+step pos", {bus.pos}, 0);
        check("clr+step idx", {bus.idx}, cur);
        for (int n = 0; n < 2; n++) tick(gray_of[cur], 1'b0, 1'b1);

        // Error counter saturation: every sample is an illegal jump.
        errs_seen = 0;
        steps_seen = 0;
        for (int n = 0; n < 300; n++) begin
            nc = (n % 2 == 0) ? gray_of[(cur + 3) % 8] : gray_of[cur];
            tick(nc, 1'b0, 1'b1);
        end
        for (int n = 0; n < 3; n++) tick(gray_of[cur], 1'b0, 1'b1);
        check("errc saturated", {bus.err_cnt}, 8'hFF);
        check("err pulses", errs_seen, 300);
        check("no steps on err", steps_seen, 0);
        check("pos after errs", {bus.pos}, 0);

        // Reset mid-walk with a code still in the synchronizer.
        cur = (cur + 1) % 8;
        for (int n = 0; n < 3; n++) tick(gray_of[cur], 1'b0, 1'b1);
        check("pre-reset pos", {bus.pos}, 1);
        cur = (cur + 1) % 8;
        tick(gray_of[cur], 1'b0, 1'b1);
        tick(gray_of[cur], 1'b0, 1'b0);
        check("rst locked", {bus.locked}, 0);
        check("rst pos", {bus.pos}, 0);
        check("rst idx", {bus.idx}, 0);
        check("rst errc", {bus.err_cnt}, 0);
        steps_seen = 0;
        errs_seen  = 0;
        for (int n = 0; n < SYNC_STAGES + 2; n++) tick(gray_of[cur], 1'b0, 1'b1);
        check("relock locked", {bus.locked}, 1);
        check("relock pos", {bus.pos}, 0);
        check("relock idx", {bus.idx}, cur);
        check("relock steps", steps_seen, 0);
        check("relock errs", errs_seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gray_seq_decoder.md
GRAY_SEQ_DECODER -- requirements
Module: gray_seq_decoder

Interface
REQ-001 Parameter POS_W, default 16: width of the signed position counter.
REQ-002 Parameter SYNC_STAGES, default 2: number of synchronizer flops on the code input (minimum 2).
REQ-003 Parameter ERRC_W, default 8: width of the saturating error counter.
REQ-004 clk  input  1  sole clock; all logic on the rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 code  input  3  Gray-coded step position from the sequence generator; asynchronous to clk.
REQ-007 clr  input  1  synchronous clear of pos and err_cnt.
REQ-008 pos  output  POS_W  signed accumulated position, two's complement.
REQ-009 idx  output  3  binary index of the last accepted code.
REQ-010 dir  output  1  direction of the last valid step: 0 = forward (increasing index), 1 = backward.
REQ-011 step_valid  output  1  one-cycle pulse per accepted single step.
REQ-012 err  output  1  one-cycle pulse per illegal transition.
REQ-013 err_cnt  output  ERRC_W  count of illegal transitions, saturating.
REQ-014 locked  output  1  high once a reference code has been captured.

Function
REQ-015 Code-to-index map SHALL be: 000->0, 100->1, 110->2, 111->3, 101->4, 001->5, 011->6, 010->7.
REQ-016 code SHALL pass through SYNC_STAGES flops; only the last stage (code_s) feeds the decoder.
REQ-017 FSM SHALL have exactly two states: SYNC and TRACK.
REQ-018 In SYNC, the first clock with code_s valid SHALL load idx from code_s, set locked=1, and move to TRACK, with no step_valid, err, or pos change.
REQ-019 In TRACK, the decoder SHALL compute delta = (map(code_s) - idx) mod 8 every cycle.
REQ-020 delta=0: no output change.
REQ-021 delta=1: pos+1, dir=0, idx updated, step_valid=1 for one cycle.
REQ-022 delta=7: pos-1, dir=1, idx updated, step_valid=1 for one cycle.
REQ-023 delta in 2..6: err=1 for one cycle, err_cnt+1 (saturating at all-ones), idx re-referenced to the new code, pos and dir unchanged, state stays TRACK.
REQ-024 pos SHALL wrap modulo 2^POS_W, so max positive +1 gives max negative and the reverse.
REQ-025 Index wrap 7->0 SHALL count as forward and 0->7 as backward.
REQ-026 Latency: a code change first sampled at edge N SHALL update pos, idx, dir, step_valid, and err at edge N+SYNC_STAGES.
REQ-027 If clr and a step occur in the same cycle, pos and err_cnt SHALL become 0 (the step is discarded from pos), while idx, dir, step_valid, and err still respond to the step.
REQ-028 step_valid and err SHALL never be high in the same cycle.

Reset
REQ-029 When rst_n=0 at a rising edge: pos=0, idx=0, dir=0, step_valid=0, err=0, err_cnt=0, locked=0, state=SYNC, and all synchronizer flops=0.
REQ-030 A reset asserted mid-operation SHALL take effect at the next edge and discard any in-flight synchronized code.
REQ-031 After rst_n rises, the block SHALL relock per REQ-018 with no step or error counted for the first code.

Structure
REQ-032 Shared package gray_seq_pkg SHALL hold the eight code constants S0..S7, the SYNC/TRACK state encoding, and the code-to-index mapping function.
REQ-033 The synchronizer SHALL be the sub-module bit_sync (width and depth parameterized).
REQ-034 All outputs SHALL be registered.

Verification
REQ-035 Reset, then hold code=000 for 5 cycles -> locked=1, pos=0, no step_valid, no err.
REQ-036 Walk forward 000,100,110,111,101,001,011,010,000, each held 4 cycles -> 8 step_valid pulses, pos=8, dir=0, idx=0, each pulse exactly SYNC_STAGES edges after the change.
REQ-037 From idx=0, step to 010 and then 011 -> pos=-2 (0xFFFE), dir=1, idx=6.
REQ-038 From 000, jump to 111 -> err pulses once, err_cnt=1, pos unchanged, idx=3; then step to 101 -> step_valid, pos+1.
REQ-039 Preload pos=0x7FFF by stepping, then one forward step -> pos=0x8000; apply clr together with a step -> pos=0, step_valid=1.
REQ-040 Assert rst_n=0 mid-walk for 1 cycle -> all outputs at reset values on the next edge, locked=0; relocks on the following sample with pos=0.
